vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing from the 50 MHz system clock. It drives the pixel-enable strobe and the raster counters consumed by the grid-to-video fetch stage. It also takes that stage's 8-bit RGB332 pixel back and emits the final registered sync and colour signals at the board pins. Sync and blanking are delayed to match the fetch stage's fixed pixel-tick latency, so colour and sync leave aligned.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_sync_delay.sv | 42 ++++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 raster and the RGB332 pixel format.
// Consumers of the raster counters import this for the active-window bounds.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int PIPE_DELAY_DEF = 2;

    // Sync END values are exclusive: the first count after the pulse.
    localparam coord_t H_TOTAL      = coord_t'(H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF);
    localparam coord_t V_TOTAL      = coord_t'(V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF);
    localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE_DEF + H_FP_DEF);
    localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF);
    localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE_DEF + V_FP_DEF);
    localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF);

    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_bits_t;

    localparam sync_bits_t SYNC_BITS_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    function automatic coord_t wrap_inc(input coord_t value, input coord_t last);
        return (value == last) ? '0 : value + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/pixel bundle between the VGA timing generator and the grid-to-video fetch stage.
// px_en is a free-running strobe with no back-pressure; the fetch stage must keep pace.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       px_en;
    coord_t     h_count;
    coord_t     v_count;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic [7:0] pixel_rgb_in;
    logic       hsync;
    logic       vsync;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;

    modport master (
        output px_en, h_count, v_count, active, line_start, frame_start,
        output hsync, vsync, vga_r, vga_g, vga_b,
        input  pixel_rgb_in
    );

    modport slave (
        input  px_en, h_count, v_count, active, line_start, frame_start,
        input  hsync, vsync, vga_r, vga_g, vga_b,
        output pixel_rgb_in
    );

endinterface

// File: rtl/vga_sync_delay.sv
// Enable-qualified shift register aligning sync/blank decodes with the pixel fetch latency.
// Every stage resets to RESET_VAL so the pins come up idle regardless of depth.
module vga_sync_delay #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en_i) begin
            stage_d[0] = d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                stage_q[i] <= RESET_VAL;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing from a 2:1 pixel strobe, plus the registered sync/colour pin stage
// whose sync path is delayed to line up with the fetch stage's pixel latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic       phase_q, phase_d;
    coord_t     h_q, h_d;
    coord_t     v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [7:0] rgb_q, rgb_d;

    sync_bits_t raw;
    sync_bits_t dly;
    logic       line_start;

    // The phase flop doubles as the pixel strobe: counters move only on its high cycles.
    always_comb begin
        phase_d = ~phase_q;
        h_d     = h_q;
        v_d     = v_q;
        if (phase_q) begin
            h_d = wrap_inc(h_q, H_LAST);
            if (h_q == H_LAST) begin
                v_d = wrap_inc(v_q, V_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            phase_q <= phase_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        raw.active = (h_q < H_ACT) && (v_q < V_ACT);
        raw.hs     = ~((h_q >= HS_START) && (h_q < HS_END));
        raw.vs     = ~((v_q >= VS_START) && (v_q < VS_END));
    end

    vga_sync_delay #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     ($bits(sync_bits_t)),
        .RESET_VAL (SYNC_BITS_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .en_i  (phase_q),
        .d_i   (raw),
        .q_o   (dly)
    );

    // The pixel arriving now belongs to the same raster position as the delayed decode.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (phase_q) begin
            hsync_d = dly.hs;
            vsync_d = dly.vs;
            rgb_d   = dly.active ? vga.pixel_rgb_in : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign line_start      = phase_q & (h_q == '0);
    assign vga.px_en       = phase_q;
    assign vga.h_count     = h_q;
    assign vga.v_count     = v_q;
    assign vga.active      = raw.active;
    assign vga.line_start  = line_start;
    assign vga.frame_start = line_start & (v_q == '0);
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.vga_r       = rgb_q[RGB_R_MSB:RGB_R_LSB];
    assign vga.vga_g       = rgb_q[RGB_G_MSB:RGB_G_LSB];
    assign vga.vga_b       = rgb_q[RGB_B_MSB:RGB_B_LSB];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
// Pin expectations are queued at the raster position they describe and retired as outputs update.
module tb_vga_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 6;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int PD  = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam logic [9:0] RESET_PINS = 10'b11_000_000_00;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .PIPE_DELAY (PD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif)
    );

    always #10 clk = ~clk;

    int         n_vec   = 0;
    int         n_err   = 0;
    int         idx     = 0;
    bit         phase_m = 1'b0;
    bit         ff_mode = 1'b0;
    logic [9:0] cur_exp = RESET_PINS;
    logic [9:0] exp_q[$];

    function automatic logic [7:0] pix(input int n);
        if (ff_mode) return 8'hFF;
        return 8'((n * 37 + 11) & 255);
    endfunction

    // {hsync, vsync, r, g, b} the pins must show for raster index n.
    function automatic logic [9:0] exp_pins(input int n);
        int h, v;
        logic hs, vs, act;
        h   = n % HT;
        v   = (n / HT) % VT;
        hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        act = (h < HA) && (v < VA);
        return {hs, vs, act ? pix(n) : 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        int h, v;
        h = idx % HT;
        v = (idx / HT) % VT;
        check("px_en", vif.px_en, phase_m);
        check("h_count", vif.h_count, h);
        check("v_count", vif.v_count, v);
        check("active", vif.active, (h < HA) && (v < VA));
        check("line_start", vif.line_start, phase_m && h == 0);
        check("frame_start", vif.frame_start, phase_m && h == 0 && v == 0);
        check("pins", {vif.hsync, vif.vsync, vif.vga_r, vif.vga_g, vif.vga_b}, cur_exp);
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (phase_m) begin
            exp_q.push_back(exp_pins(idx));
            cur_exp = exp_q.pop_front();
            idx++;
        end
        phase_m = !phase_m;
        #1;
        check_all();
        vif.pixel_rgb_in = pix(idx - PD);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_px_en", vif.px_en, 1'b0);
            check("rst_h", vif.h_count, 0);
            check("rst_v", vif.v_count, 0);
            check("rst_hsync", vif.hsync, 1'b1);
            check("rst_vsync", vif.vsync, 1'b1);
            check("rst_rgb", {vif.vga_r, vif.vga_g, vif.vga_b}, 0);
        end
        exp_q.delete();
        for (int i = 0; i < PD; i++) exp_q.push_back(RESET_PINS);
        cur_exp = RESET_PINS;
        idx     = 0;
        phase_m = 1'b0;
        vif.pixel_rgb_in = pix(-PD);
        reset   = 1'b0;
    endtask

    initial begin
        int cnt, nz, runs, run_len;
        bit cur_nz, prev_nz;

        vif.pixel_rgb_in = 8'h00;
        do_reset(5);

        clk_step();
        check("first_frame_start", vif.frame_start, 1'b1);

        // Line length between line_start pulses.
        cnt = 0;
        while (vif.line_start !== 1'b1 && cnt < 4 * HT) begin clk_step(); cnt++; end
        check("line_start_seen", vif.line_start, 1'b1);
        cnt = 0;
        do begin clk_step(); cnt++; end while (vif.line_start !== 1'b1 && cnt < 4 * HT);
        check("line_len_clk", cnt, 2 * HT);

        // hsync fall position and width.
        cnt = 0;
        while (vif.hsync !== 1'b1 && cnt < 4 * HT) begin clk_step(); cnt++; end
        cnt = 0;
        while (vif.hsync !== 1'b0 && cnt < 4 * HT) begin clk_step(); cnt++; end
        check("hsync_fall_h", idx % HT, (HA + HFP + PD + 1) % HT);
        cnt = 0;
        while (vif.hsync === 1'b0 && cnt < 4 * HT) begin clk_step(); cnt++; end
        check("hsync_low_clk", cnt, 2 * HS);

        // Frame length between frame_start pulses.
        cnt = 0;
        while (vif.frame_start !== 1'b1 && cnt < 4 * HT * VT) begin clk_step(); cnt++; end
        check("frame_start_seen", vif.frame_start, 1'b1);
        cnt = 0;
        do begin clk_step(); cnt++; end while (vif.frame_start !== 1'b1 && cnt < 4 * HT * VT);
        check("frame_len_clk", cnt, 2 * HT * VT);

        // vsync width.
        cnt = 0;
        while (vif.vsync !== 1'b0 && cnt < 4 * HT * VT) begin clk_step(); cnt++; end
        check("vsync_seen", vif.vsync, 1'b0);
        cnt = 0;
        while (vif.vsync === 1'b0 && cnt < 4 * HT * VT) begin clk_step(); cnt++; end
        check("vsync_low_clk", cnt, 2 * HT * VS);

        // Simultaneous wrap of both counters.
        cnt = 0;
        while (!(idx % HT == HT - 1 && (idx / HT) % VT == VT - 1 && phase_m) && cnt < 4 * HT * VT) begin
            clk_step(); cnt++;
        end
        check("wrap_h_before", vif.h_count, HT - 1);
        check("wrap_v_before", vif.v_count, VT - 1);
        clk_step();
        check("wrap_h_after", vif.h_count, 0);
        check("wrap_v_after", vif.v_count, 0);

        // Mid-frame reset for one clk.
        cnt = 0;
        while (!(idx % HT == 9 && (idx / HT) % VT == 7 && phase_m) && cnt < 4 * HT * VT) begin
            clk_step(); cnt++;
        end
        check("midreset_h", vif.h_count, 9);
        check("midreset_v", vif.v_count, 7);
        do_reset(1);
        clk_step();
        check("restart_frame_start", vif.frame_start, 1'b1);
        for (int i = 0; i < 3 * HT; i++) clk_step();

        // Constant white: only the visible window may carry colour.
        ff_mode = 1'b1;
        do_reset(2);
        nz = 0; runs = 0; run_len = 0; prev_nz = 1'b0;
        for (int t = 0; t < 4 * HT * VT; t++) begin
            clk_step();
            if (!phase_m) begin
                cur_nz = ({vif.vga_r, vif.vga_g, vif.vga_b} != 8'h00);
                if (cur_nz && !prev_nz) begin runs++; run_len = 0; end
                if (cur_nz) begin nz++; run_len++; end
                if (!cur_nz && prev_nz) check("line_visible_px", run_len, HA);
                prev_nz = cur_nz;
            end
        end
        check("visible_px_total", nz, 2 * HA * VA);
        check("visible_lines", runs, 2 * VA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
